vchip8_pio_in_irq: RTL



---
 rtl/vchip8_pio_in_irq.sv | 132 +++++++++++++
 1 files changed

// File: rtl/vchip8_pio_in_irq.sv
// vCHIP-8 input PIO: synchronises and debounces the keypad/switch/button bus,
// captures per-bit edges and raises a maskable level interrupt. Registers sit
// on a 2-bit word-addressed Avalon-MM slave with one cycle of read latency.
module vchip8_pio_in_irq #(
   parameter int WIDTH           = 8,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int EDGE_TYPE       = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic             irq
);

   logic [WIDTH-1:0] r_sync [SYNC_STAGES];
   logic [WIDTH-1:0] w_sync;
   logic [WIDTH-1:0] w_stable;
   logic [WIDTH-1:0] r_stable_d;
   logic [WIDTH-1:0] w_edge;
   logic [WIDTH-1:0] r_mask;
   logic [WIDTH-1:0] r_edgecap;
   logic [WIDTH-1:0] w_wdata;
   logic             w_wr;
   logic [31:0]      w_rd_mux;
   logic             w_unused_wdata;

   assign w_wr    = chipselect & ~write_n;
   assign w_wdata = writedata[WIDTH-1:0];

   // Bits of writedata above WIDTH have no register behind them.
   assign w_unused_wdata = &{1'b0, writedata};

   // Per-bit synchroniser chain for the asynchronous pins.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
      end else begin
         r_sync[0] <= in_port;
         for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
      end
   end

   assign w_sync = r_sync[SYNC_STAGES-1];

   generate
      if (DEBOUNCE_CYCLES == 0) begin : g_bypass
         // No filtering: the synchroniser output is the accepted level.
         assign w_stable = w_sync;
      end else begin : g_debounce
         localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
         localparam logic [CW-1:0] TC = CW'(DEBOUNCE_CYCLES - 1);

         logic [WIDTH-1:0] r_stable;
         logic [CW-1:0]    r_cnt [WIDTH];

         // Accept a new level only after it has differed from the current
         // level for DEBOUNCE_CYCLES consecutive cycles.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               r_stable <= '0;
               for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
            end else begin
               for (int i = 0; i < WIDTH; i++) begin
                  if (w_sync[i] == r_stable[i]) begin
                     r_cnt[i] <= '0;
                  end else if (r_cnt[i] == TC) begin
                     r_stable[i] <= w_sync[i];
                     r_cnt[i]    <= '0;
                  end else begin
                     r_cnt[i] <= r_cnt[i] + CW'(1);
                  end
               end
            end
         end

         assign w_stable = r_stable;
      end
   endgenerate

   // Delayed copy of the accepted level for edge detection.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_stable_d <= '0;
      else       r_stable_d <= w_stable;
   end

   // Edge polarity selected at elaboration time.
   always_comb begin
      w_edge = '0;
      if (EDGE_TYPE == 0)      w_edge = w_stable & ~r_stable_d;
      else if (EDGE_TYPE == 1) w_edge = ~w_stable & r_stable_d;
      else                     w_edge = w_stable ^ r_stable_d;
   end

   // Interrupt mask register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                        r_mask <= '0;
      else if (w_wr && address == 2'd2) r_mask <= w_wdata;
   end

   // Edge capture: sticky until write-1-to-clear; a fresh edge beats a clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                        r_edgecap <= '0;
      else if (w_wr && address == 2'd3) r_edgecap <= (r_edgecap & ~w_wdata) | w_edge;
      else                              r_edgecap <= r_edgecap | w_edge;
   end

   // Read mux, zero-extended to the 32-bit bus.
   always_comb begin
      w_rd_mux = '0;
      case (address)
         2'd0:    w_rd_mux[WIDTH-1:0] = w_stable;
         2'd2:    w_rd_mux[WIDTH-1:0] = r_mask;
         2'd3:    w_rd_mux[WIDTH-1:0] = r_edgecap;
         default: w_rd_mux = '0;
      endcase
   end

   // Read data registered every cycle, independent of chipselect.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) readdata <= '0;
      else       readdata <= w_rd_mux;
   end

   assign irq = |(r_edgecap & r_mask);

endmodule
